// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming unsigned multiply-accumulate over a valid/ready pair stream; define MAC_SATURATE_EN for saturating accumulation
module mac_accumulator #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_terms,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_sum
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [31:0]        acc, prod_q, acc_next;
    logic               prod_v, hs, go;
    logic [COUNT_W-1:0] remaining;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign out_sum   = out_valid ? acc : 32'd0;
    assign hs        = in_valid && in_ready;
    assign go        = state == IDLE && start;

`ifdef MAC_SATURATE_EN
    logic [32:0] sum_w;
    assign sum_w    = {1'b0, acc} + {1'b0, prod_q};
    assign acc_next = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
`else
    assign acc_next = acc + prod_q;
`endif

    // Control state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: the last handshake or an empty request goes through one DRAIN cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_terms == '0) ? DRAIN : ACCUM;
            ACCUM:   if (hs && remaining == COUNT_W'(1)) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Product register feeds the accumulator one cycle later; start clears the running sum
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            remaining <= '0;
        end else begin
            prod_v <= hs;
            if (hs) begin
                prod_q    <= in_a * in_b;
                remaining <= remaining - COUNT_W'(1);
            end
            if (go) begin
                acc       <= '0;
                remaining <= num_terms;
            end else if (prod_v) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for mac_accumulator (honours MAC_SATURATE_EN)
module tb_mac_accumulator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_terms = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pa[8];
    logic [31:0] pb[8];
    logic [31:0] sb[$];

    mac_accumulator #(.COUNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int n);
        logic [31:0] acc, p;
        logic [32:0] s;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            p = pa[i] * pb[i];
            s = {1'b0, acc} + {1'b0, p};
`ifdef MAC_SATURATE_EN
            acc = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
            acc = s[31:0];
`endif
        end
        return acc;
    endfunction

    task automatic run(input string tag, input int n, input int gap_max, input int hold);
        logic [31:0] exp;
        sb.push_back(model(n));
        start = 1'b1;
        num_terms = 16'(n);
        step();
        start = 1'b0;
        check({tag, "_ready_after_start"}, 32'(in_ready), (n == 0) ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0 && i > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max, 1)) begin
                    step();
                    check({tag, "_ready_in_gap"}, 32'(in_ready), 32'd1);
                end
            end
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            step();
        end
        if (n != 0) begin
            in_a = 32'd100;
            in_b = 32'd100;
        end
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        exp = sb.pop_front();
        check({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, out_sum, exp);
        repeat (hold) begin
            start = 1'b1;
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, out_sum, exp);
        end
        start = hold > 0;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        step();
        step();
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_sum", out_sum, 32'd0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(in_ready), 32'd0);

        pa[0] = 32'd2; pb[0] = 32'd3;
        pa[1] = 32'd4; pb[1] = 32'd5;
        pa[2] = 32'd6; pb[2] = 32'd7;
        check("model_68", model(3), 32'd68);
        run("b2b", 3, 0, 0);
        run("gaps", 3, 3, 0);
        run("zero", 0, 0, 0);

        pa[0] = 32'hFFFF_FFFF; pb[0] = 32'd1;
        pa[1] = 32'd2;         pb[1] = 32'd1;
        run("wrap", 2, 0, 0);

        pa[0] = 32'h0001_0000; pb[0] = 32'h0001_0003;
        pa[1] = 32'h1234_5678; pb[1] = 32'd9;
        run("trunc", 2, 0, 0);

        for (int i = 0; i < 6; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        run("rand", 6, 2, 0);

        pa[0] = 32'd11; pb[0] = 32'd13;
        run("hold", 1, 0, 5);

        start = 1'b1;
        num_terms = 16'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 32'd9; in_b = 32'd9;
        step();
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        step();
        check("abort_idle_valid", 32'(out_valid), 32'd0);

        pa[0] = 32'd1; pb[0] = 32'd1;
        run("after_abort", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
